// File: rtl/imem_fetch_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Purpose  : Shared fault codes, default NOP word, FSM state encoding and
//            the fetch-address classifier for the instruction-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // ADDI x0,x0,0 - harmless filler handed to decode on any faulted fetch
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misalignment wins over range so a bad low-order pair is always reported
  // first; the range test uses the full 30-bit word index, so high addresses
  // never alias back into the array.
  function automatic logic [1:0] classify_addr(input logic [31:0] addr,
                                               input int unsigned depth);
    logic [1:0] f;
    if (addr[1:0] != 2'b00) begin
      f = FAULT_MISALIGN;
    end else if ({2'b00, addr[31:2]} >= depth) begin
      f = FAULT_RANGE;
    end else begin
      f = FAULT_OK;
    end
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_fetch_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_if
// Purpose  : Fetch request / response handshake bundle between the PC fetch
//            stage (master) and the instruction-memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface imem_fetch_if;

  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_fault;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

endinterface
`default_nettype wire

// File: rtl/imem_fetch_responder_array.sv
`default_nettype none
// ============================================================================
// Module   : imem_array
// Purpose  : DEPTH_WORDS x 32 instruction store, one synchronous write port
//            and one registered read port. A read and a write to the same
//            index on the same edge return the old word.
// Revision : 1.0 - initial release
// ============================================================================
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  wire logic          clk,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [31:0]   i_wdata,
  input  wire logic          i_re,
  input  wire logic [AW-1:0] i_raddr,
  output logic      [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  // Storage is deliberately never reset so a loaded image survives a reset;
  // non-blocking semantics give read-before-write on a shared index.
  always_ff @(posedge clk) begin
    if (i_we && (32'(i_waddr) < DEPTH_WORDS)) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_responder
// Purpose  : Accepts PC fetch requests, classifies the address, reads the
//            instruction store and answers after WAIT_STATES cycles (faults
//            answer immediately with a NOP) over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 256,
  parameter  int unsigned WAIT_STATES = 1,
  parameter  logic [31:0] NOP_INSTR   = NOP_INSTR_DEFAULT,
  localparam int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  wire logic          clk,
  input  wire logic          Areset,
  imem_fetch_if.slave        bus,
  input  wire logic          prog_we,
  input  wire logic [AW-1:0] prog_waddr,
  input  wire logic [31:0]   prog_wdata
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [31:0] r_addr;
  logic [1:0]  r_fault;
  logic        r_use_data;

  logic          w_accept;
  logic [1:0]    w_fault;
  logic          w_re;
  logic [AW-1:0] w_ridx;
  logic [31:0]   w_rdata;

  assign w_fault       = classify_addr(bus.req_addr, DEPTH_WORDS);
  assign bus.req_ready = (r_state == IDLE) && Areset;
  assign w_accept      = bus.req_valid && bus.req_ready;
  // Faulted fetches skip the array so an out-of-range index is never used
  assign w_re          = w_accept && (w_fault == FAULT_OK);
  assign w_ridx        = bus.req_addr[AW+1:2];

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (prog_we),
    .i_waddr (prog_waddr),
    .i_wdata (prog_wdata),
    .i_re    (w_re),
    .i_raddr (w_ridx),
    .o_rdata (w_rdata)
  );

  // Next-state and wait-counter logic; faults bypass WAIT entirely
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if ((WAIT_STATES != 0) && (w_fault == FAULT_OK)) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 4'(WAIT_STATES);
          end else begin
            w_state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and counter registers; reset abandons any fetch in flight
  always_ff @(posedge clk) begin
    if (!Areset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the request context at acceptance; held untouched until next one
  always_ff @(posedge clk) begin
    if (!Areset) begin
      r_addr     <= 32'd0;
      r_fault    <= FAULT_OK;
      r_use_data <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= bus.req_addr;
      r_fault    <= w_fault;
      r_use_data <= (w_fault == FAULT_OK);
    end
  end

  // Array read register only updates on acceptance, so it stays stable
  // through WAIT and RESP and later writes cannot disturb it.
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_instr = r_use_data ? w_rdata : NOP_INSTR;
  assign bus.rsp_addr  = r_addr;
  assign bus.rsp_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_responder
// Purpose  : Directed, table-driven bench for imem_fetch_responder with a
//            WAIT_STATES=1 instance and a WAIT_STATES=3 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        Areset;
  logic        prog_we;
  logic [7:0]  prog_waddr;
  logic [31:0] prog_wdata;

  int tests = 0;
  int fails = 0;

  imem_fetch_if bus1();
  imem_fetch_if bus3();

  always #5 clk = ~clk;

  imem_fetch_responder #(
    .DEPTH_WORDS (256),
    .WAIT_STATES (1),
    .NOP_INSTR   (NOP)
  ) dut1 (
    .clk        (clk),
    .Areset     (Areset),
    .bus        (bus1),
    .prog_we    (prog_we),
    .prog_waddr (prog_waddr),
    .prog_wdata (prog_wdata)
  );

  imem_fetch_responder #(
    .DEPTH_WORDS (256),
    .WAIT_STATES (3),
    .NOP_INSTR   (NOP)
  ) dut3 (
    .clk        (clk),
    .Areset     (Areset),
    .bus        (bus3),
    .prog_we    (prog_we),
    .prog_waddr (prog_waddr),
    .prog_wdata (prog_wdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  fault;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic prog_write(input logic [7:0] idx, input logic [31:0] d);
    prog_we    = 1'b1;
    prog_waddr = idx;
    prog_wdata = d;
    @(posedge clk); #1;
    prog_we    = 1'b0;
  endtask

  // Present a request on bus1 (optionally with a write on the acceptance
  // edge) and return cycles from acceptance to the first rsp_valid cycle.
  task automatic issue1(input logic [31:0] a, input logic wr, input logic [7:0] widx,
                        input logic [31:0] wd, output int lat);
    int n;
    n = 0;
    bus1.req_valid = 1'b1;
    bus1.req_addr  = a;
    while (!bus1.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_before_accept", {31'd0, bus1.req_ready}, 32'd1);
    if (wr) begin
      prog_we    = 1'b1;
      prog_waddr = widx;
      prog_wdata = wd;
    end
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    prog_we        = 1'b0;
    lat = 1;
    while (!bus1.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic complete1();
    bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.rsp_ready = 1'b0;
  endtask

  task automatic issue3(input logic [31:0] a, output int lat);
    int n;
    n = 0;
    bus3.req_valid = 1'b1;
    bus3.req_addr  = a;
    while (!bus3.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    lat = 1;
    while (!bus3.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic complete3();
    bus3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus3.rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vecs[0] = '{32'h0000_000C, 32'h0050_0093, 2'b00, 2};
    vecs[1] = '{32'h0000_0006, NOP,           2'b01, 1};
    vecs[2] = '{32'h0000_0400, NOP,           2'b10, 1};
    vecs[3] = '{32'h0000_03FC, 32'h1234_5678, 2'b00, 2};
    vecs[4] = '{32'hFFFF_FFFC, NOP,           2'b10, 1};
    vecs[5] = '{32'hFFFF_FFFF, NOP,           2'b01, 1};
    vecs[6] = '{32'h0000_0000, 32'hAAAA_0001, 2'b00, 2};
    vecs[7] = '{32'h0000_0401, NOP,           2'b01, 1};

    Areset         = 1'b0;
    prog_we        = 1'b0;
    prog_waddr     = 8'd0;
    prog_wdata     = 32'd0;
    bus1.req_valid = 1'b0;
    bus1.req_addr  = 32'd0;
    bus1.rsp_ready = 1'b0;
    bus3.req_valid = 1'b0;
    bus3.req_addr  = 32'd0;
    bus3.rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    chk("rst_rsp_instr", bus1.rsp_instr, NOP);
    chk("rst_rsp_addr",  bus1.rsp_addr, 32'd0);
    chk("rst_rsp_fault", {30'd0, bus1.rsp_fault}, 32'd0);
    chk("rst_req_ready_low", {31'd0, bus1.req_ready}, 32'd0);
    Areset = 1'b1;
    #1;
    chk("req_ready_after_rst", {31'd0, bus1.req_ready}, 32'd1);

    // Program image
    prog_write(8'd3,   32'h0050_0093);
    prog_write(8'd255, 32'h1234_5678);
    prog_write(8'd0,   32'hAAAA_0001);

    // Table-driven fetches
    for (int i = 0; i < 8; i++) begin
      issue1(vecs[i].addr, 1'b0, 8'd0, 32'd0, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_instr", i), bus1.rsp_instr, vecs[i].instr);
      chk($sformatf("vec%0d_addr", i),  bus1.rsp_addr, vecs[i].addr);
      chk($sformatf("vec%0d_fault", i), {30'd0, bus1.rsp_fault}, {30'd0, vecs[i].fault});
      complete1();
    end

    // Back-pressure: response held stable for 5 cycles
    issue1(32'h0000_000C, 1'b0, 8'd0, 32'd0, lat);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), {31'd0, bus1.rsp_valid}, 32'd1);
      chk($sformatf("stall%0d_instr", k), bus1.rsp_instr, 32'h0050_0093);
      chk($sformatf("stall%0d_addr", k),  bus1.rsp_addr, 32'h0000_000C);
      chk($sformatf("stall%0d_fault", k), {30'd0, bus1.rsp_fault}, 32'd0);
      chk($sformatf("stall%0d_req_ready", k), {31'd0, bus1.req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    complete1();
    chk("post_stall_req_ready", {31'd0, bus1.req_ready}, 32'd1);
    chk("post_stall_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);

    // Write on the acceptance edge: old word returned, new word next time
    issue1(32'h0000_000C, 1'b1, 8'd3, 32'hDEAD_BEEF, lat);
    chk("rbw_instr_old", bus1.rsp_instr, 32'h0050_0093);
    complete1();
    issue1(32'h0000_000C, 1'b0, 8'd0, 32'd0, lat);
    chk("rbw_instr_new", bus1.rsp_instr, 32'hDEAD_BEEF);
    complete1();

    // Write landing during WAIT is invisible to the pending fetch
    bus1.req_valid = 1'b1;
    bus1.req_addr  = 32'h0000_0000;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    chk("wwait_in_wait", {31'd0, bus1.rsp_valid}, 32'd0);
    prog_we    = 1'b1;
    prog_waddr = 8'd0;
    prog_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    prog_we = 1'b0;
    chk("wwait_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd1);
    chk("wwait_instr_old", bus1.rsp_instr, 32'hAAAA_0001);
    complete1();
    issue1(32'h0000_0000, 1'b0, 8'd0, 32'd0, lat);
    chk("wwait_instr_new", bus1.rsp_instr, 32'h5555_5555);
    complete1();

    // Reset during WAIT abandons the fetch, array preserved
    bus1.req_valid = 1'b1;
    bus1.req_addr  = 32'h0000_03FC;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    Areset = 1'b0;
    @(posedge clk); #1;
    Areset = 1'b1;
    #1;
    chk("rstwait_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    chk("rstwait_req_ready", {31'd0, bus1.req_ready}, 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rstwait_no_rsp", {31'd0, bus1.rsp_valid}, 32'd0);
    end
    issue1(32'h0000_03FC, 1'b0, 8'd0, 32'd0, lat);
    chk("rstwait_refetch_lat", 32'(lat), 32'd2);
    chk("rstwait_refetch_instr", bus1.rsp_instr, 32'h1234_5678);
    complete1();

    // WAIT_STATES=3 instance: faults skip waits, OK fetch takes 4 cycles
    issue3(32'h0000_0006, lat);
    chk("ws3_mis_latency", 32'(lat), 32'd1);
    chk("ws3_mis_fault", {30'd0, bus3.rsp_fault}, 32'd1);
    chk("ws3_mis_instr", bus3.rsp_instr, NOP);
    complete3();
    issue3(32'h0000_000C, lat);
    chk("ws3_ok_latency", 32'(lat), 32'd4);
    chk("ws3_ok_instr", bus3.rsp_instr, 32'hDEAD_BEEF);
    chk("ws3_ok_fault", {30'd0, bus3.rsp_fault}, 32'd0);
    complete3();
    chk("ws3_idle_ready", {31'd0, bus3.req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder on the far end of the program-counter fetch interface.
- Accepts a fetch request carrying the PC byte address and looks up a word-addressed instruction store.
- After a configurable wait-state delay, it returns the 32-bit instruction plus a fault code to the decode stage through a valid/ready handshake.
- A separate write port loads the program image before or between runs.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words held; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_STATES, 1, extra cycles between request acceptance and response; legal range 0..15.
- NOP_INSTR, 32'h00000013, word returned on any faulted fetch (ADDI x0,x0,0).

Ports:
- clk  in  1  clock, rising-edge.
- Areset  in  1  reset, synchronous, active-low.
- req_valid  in  1  fetch request present.
- req_addr  in  32  PC byte address of the requested instruction.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  response fields valid.
- rsp_ready  in  1  consumer accepts the response this cycle.
- rsp_instr  out  32  fetched instruction, or NOP_INSTR on fault.
- rsp_addr  out  32  echo of the accepted req_addr.
- rsp_fault  out  2  00 OK, 01 misaligned, 10 out of range.
- prog_we  in  1  program-load write enable.
- prog_waddr  in  clog2(DEPTH_WORDS)  word index to write.
- prog_wdata  in  32  word to write.

Behaviour:
- Reset, sampled on a clk edge while Areset=0:
  - state=IDLE, rsp_valid=0, rsp_instr=NOP_INSTR, rsp_addr=0, rsp_fault=00, wait counter=0.
  - The storage array is not cleared.
- req_ready = (state==IDLE) and Areset=1. It is combinational from state only, never from req_valid.
- A request is accepted on an edge where req_valid & req_ready. At acceptance the block:
  - registers req_addr;
  - classifies the address, misaligned taking priority: req_addr[1:0]!=0 -> 01; else word index req_addr[31:2] >= DEPTH_WORDS -> 10; else 00;
  - issues the array read for index req_addr[31:2]. The read is read-before-write: a same-cycle prog_we to the same index returns the old word.
- States:
  - IDLE -> WAIT on acceptance when WAIT_STATES>0 and fault=00. The counter loads WAIT_STATES.
  - IDLE -> RESP on acceptance when WAIT_STATES==0 or fault!=00. Faults never incur wait states.
  - WAIT: the counter decrements each cycle. WAIT -> RESP on the edge where the counter equals 1.
  - RESP: rsp_valid=1, all rsp_* fields held stable. RESP -> IDLE on the edge where rsp_ready=1.
- Latency from the acceptance edge to the first rsp_valid=1 cycle:
  - OK fetch: 1+WAIT_STATES cycles.
  - Faulted fetch: 1 cycle.
- Throughput is at most one fetch per 2+WAIT_STATES cycles. There is no overlap of request and response.
- On fault, rsp_instr=NOP_INSTR and no array read data is used.
- Writes:
  - prog_we writes are accepted in every state and take effect at the edge.
  - A write landing during WAIT to the pending index is not visible to that fetch, because data was captured at acceptance.
- Reset during WAIT or RESP abandons the pending fetch. rsp_valid drops on that edge and no response is produced.
- Address 0xFFFFFFFC (maximum) reports out of range; there is no wrap-around into the array.

Decomposition:
- Shared package, imem_pkg:
  - fault code constants FAULT_OK=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10;
  - NOP_INSTR default;
  - state encoding IDLE/WAIT/RESP.
- One sub-module, imem_array: DEPTH_WORDS x 32 storage with one synchronous write port and one registered read port, read-before-write. The FSM, classifier and response registers stay in the top module.

Test Plan:
- Load word 3 = 32'h00500093 via prog_we. Then, with WAIT_STATES=1, request addr 32'h0000000C -> rsp_valid rises 2 cycles after acceptance, rsp_instr=32'h00500093, rsp_addr=32'h0C, rsp_fault=00.
- Request addr 32'h00000006 -> rsp_valid 1 cycle after acceptance, rsp_fault=01, rsp_instr=32'h00000013, with no wait states even when WAIT_STATES=3.
- With DEPTH_WORDS=256, request addr 32'h00000400 -> fault=10 and NOP returned. Request 32'h000003FC -> fault=00.
- Hold rsp_ready=0 for 5 cycles in RESP -> all rsp_* fields remain stable and req_ready=0 throughout. Raise rsp_ready -> next cycle req_ready=1.
- Write word 3 = 32'hDEADBEEF in the acceptance cycle of a fetch of addr 32'h0C -> response carries the old word. A second fetch returns 32'hDEADBEEF.
- Drive Areset=0 for one edge during WAIT -> rsp_valid stays 0, state returns to IDLE, and earlier-loaded array contents are preserved on the next fetch.
